th_fnd_display: RTL and testbench

Downstream consumer of the DHT11 controller's `humidity` and `temperature` bytes. It captures a new reading on a valid strobe and converts both bytes to BCD with a sequential double-dabble. It then drives a 4-digit common-anode 7-segment display by time-multiplexed scanning, showing humidity on the left pair and temperature on the right pair.

---
 rtl/fnd_pkg.sv | 54 +++++
 rtl/bin2bcd_seq.sv | 45 ++++
 rtl/th_fnd_display.sv | 132 +++++++++++++
 tb/tb_th_fnd_display.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the DHT11 7-segment display block:
// segment codes, FSM encoding and BCD-to-digit-pair formatting.
package fnd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } fnd_state_t;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Returns {tens_seg, ones_seg}; values above 99 cannot fit two digits.
    function automatic logic [15:0] fmt_byte(input logic [11:0] bcd);
        logic [15:0] r;
        if (bcd[11:8] != 4'd0)
            r = {SEG_DASH, SEG_DASH};
        else if (bcd[7:4] == 4'd0)
            r = {SEG_BLANK, seg_of(bcd[3:0])};
        else
            r = {seg_of(bcd[7:4]), seg_of(bcd[3:0])};
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 12-bit BCD converter (double-dabble),
// one shift-and-add-3 iteration per clock, eight iterations per start.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [7:0] sh;
    logic [2:0] iter;
    logic       run;
    logic [7:0] adj;

    // Hundreds never exceeds 2 for an 8-bit input, so only tens/ones need correction.
    always_comb begin
        adj = bcd[7:0];
        if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
        if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh   <= '0;
            bcd  <= '0;
            iter <= '0;
            run  <= 1'b0;
        end else if (start) begin
            sh   <= bin;
            bcd  <= '0;
            iter <= '0;
            run  <= 1'b1;
        end else if (run) begin
            bcd  <= {bcd[10:8], adj, sh[7]};
            sh   <= {sh[6:0], 1'b0};
            iter <= iter + 3'd1;
            if (iter == 3'd7) run <= 1'b0;
        end
    end

    assign done = run && (iter == 3'd7);

endmodule

// File: rtl/th_fnd_display.sv
// Captures DHT11 humidity/temperature, converts to BCD and scans them onto a
// 4-digit common-anode display: humidity on the left pair, temperature right.
module th_fnd_display
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    input  logic       data_valid,
    output logic       busy,
    output logic [7:0] seg_7,
    output logic [3:0] com
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    fnd_state_t state, state_nx;

    logic        pending;
    logic [7:0]  pend_h, pend_t;
    logic        start;
    logic [7:0]  src_h, src_t;
    logic        done_h, done_t;
    logic [11:0] bcd_h, bcd_t;

    logic [3:0][7:0] disp;
    logic [CW-1:0]   scan_cnt;
    logic [1:0]      dig;

    bin2bcd_seq u_bcd_h (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin     (src_h),
        .done    (done_h),
        .bcd     (bcd_h)
    );

    bin2bcd_seq u_bcd_t (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin     (src_t),
        .done    (done_t),
        .bcd     (bcd_t)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // A pending reading restarts conversion straight from LOAD, skipping IDLE.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        src_h    = humidity;
        src_t    = temperature;
        case (state)
            ST_IDLE: begin
                if (data_valid) begin
                    start    = 1'b1;
                    state_nx = ST_CONV;
                end
            end
            ST_CONV: begin
                if (done_h && done_t) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                if (pending) begin
                    start    = 1'b1;
                    src_h    = pend_h;
                    src_t    = pend_t;
                    state_nx = ST_CONV;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // A new pulse always wins over the LOAD-time clear so the newest reading is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            pend_h  <= '0;
            pend_t  <= '0;
        end else if (data_valid && state != ST_IDLE) begin
            pending <= 1'b1;
            pend_h  <= humidity;
            pend_t  <= temperature;
        end else if (state == ST_LOAD) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp <= {4{SEG_DASH}};
        end else if (state == ST_LOAD) begin
            disp[3:2] <= fmt_byte(bcd_h);
            disp[1:0] <= fmt_byte(bcd_t);
        end
    end

    // seg_7 and com are registered together so segments never pair with the wrong enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            dig      <= 2'd3;
            seg_7    <= SEG_BLANK;
            com      <= 4'b1111;
        end else begin
            seg_7 <= disp[dig];
            com   <= ~(4'b0001 << dig);
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                dig      <= dig - 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_th_fnd_display.sv
// Self-checking bench for th_fnd_display: directed display scenarios plus
// random data_valid traffic compared cycle by cycle against a behavioural model.
module tb_th_fnd_display;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] humidity;
    logic [7:0] temperature;
    logic       data_valid;
    logic       busy;
    logic [7:0] seg_7;
    logic [3:0] com;

    int n_vec = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    th_fnd_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .humidity    (humidity),
        .temperature (temperature),
        .data_valid  (data_valid),
        .busy        (busy),
        .seg_7       (seg_7),
        .com         (com)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [15:0] fmt(input int v);
        if (v > 99)      return {8'hBF, 8'hBF};
        if (v / 10 == 0) return {8'hFF, segtab[v % 10]};
        return {segtab[v / 10], segtab[v % 10]};
    endfunction

    int         t_edge;
    int         m_idx;
    int         m_load;
    logic       m_active, m_pend_v, m_was_active;
    logic [7:0] m_cur_h, m_cur_t, m_pend_h, m_pend_t;
    logic [7:0] m_disp [4];
    logic [15:0] m_tmp;
    logic [7:0] exp_seg;
    logic [3:0] exp_com;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_edge   = 0;
            for (int d = 0; d < 4; d++) m_disp[d] = 8'hBF;
            m_active = 1'b0;
            m_pend_v = 1'b0;
            m_load   = 0;
            exp_seg  = 8'hFF;
            exp_com  = 4'hF;
        end else begin
            t_edge  = t_edge + 1;
            m_idx   = 3 - (((t_edge - 1) / SCAN_DIV) % 4);
            exp_com = 4'hF;
            exp_com[m_idx] = 1'b0;
            exp_seg = m_disp[m_idx];
            m_was_active = m_active;
            if (m_active && t_edge == m_load) begin
                m_tmp = fmt(int'(m_cur_h));
                m_disp[3] = m_tmp[15:8];
                m_disp[2] = m_tmp[7:0];
                m_tmp = fmt(int'(m_cur_t));
                m_disp[1] = m_tmp[15:8];
                m_disp[0] = m_tmp[7:0];
                if (m_pend_v) begin
                    m_cur_h  = m_pend_h;
                    m_cur_t  = m_pend_t;
                    m_pend_v = 1'b0;
                    m_load   = t_edge + 9;
                end else begin
                    m_active = 1'b0;
                end
            end
            if (data_valid) begin
                if (!m_was_active) begin
                    m_cur_h  = humidity;
                    m_cur_t  = temperature;
                    m_active = 1'b1;
                    m_load   = t_edge + 9;
                end else begin
                    m_pend_h = humidity;
                    m_pend_t = temperature;
                    m_pend_v = 1'b1;
                end
            end
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("seg_7", 32'(seg_7), 32'(exp_seg));
            chk("com", 32'(com), 32'(exp_com));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input logic [7:0] h, input logic [7:0] t);
        @(negedge clk);
        humidity    = h;
        temperature = t;
        data_valid  = 1'b1;
        @(negedge clk);
        data_valid  = 1'b0;
    endtask

    task automatic count_busy(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (busy) cnt++;
            @(negedge clk);
        end
    endtask

    task automatic expect_digits(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                                 input logic [7:0] e1, input logic [7:0] e0);
        logic [7:0] got [4];
        for (int d = 0; d < 4; d++) got[d] = 8'h00;
        for (int i = 0; i < 4 * SCAN_DIV + 4; i++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++)
                if (com == ~(4'b0001 << d)) got[d] = seg_7;
        end
        chk({tag, ".d3"}, 32'(got[3]), 32'(e3));
        chk({tag, ".d2"}, 32'(got[2]), 32'(e2));
        chk({tag, ".d1"}, 32'(got[1]), 32'(e1));
        chk({tag, ".d0"}, 32'(got[0]), 32'(e0));
    endtask

    int         bcnt;
    logic       saw_first;
    logic [7:0] first_code [4] = '{8'h92, 8'hA4, 8'hC0, 8'h80};

    initial begin
        reset_n     = 1'b1;
        humidity    = '0;
        temperature = '0;
        data_valid  = 1'b0;
        #2 reset_n  = 1'b0;
        #20;
        chk("rst.seg_7", 32'(seg_7), 32'hFF);
        chk("rst.com", 32'(com), 32'hF);
        chk("rst.busy", 32'(busy), 32'h0);
        mon_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        expect_digits("idle", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

        pulse(8'd80, 8'd25);
        count_busy(30, bcnt);
        chk("busy_len_80_25", 32'(bcnt), 32'd9);
        expect_digits("d80_25", 8'h80, 8'hC0, 8'hA4, 8'h92);

        pulse(8'd5, 8'd0);
        count_busy(30, bcnt);
        expect_digits("d5_0", 8'hFF, 8'h92, 8'hFF, 8'hC0);

        pulse(8'd120, 8'd99);
        count_busy(30, bcnt);
        expect_digits("d120_99", 8'hBF, 8'hBF, 8'h90, 8'h90);

        // Back-to-back: first reading, then two pulses while busy.
        bcnt = 0;
        saw_first = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            data_valid = 1'b0;
            if (i == 0) begin humidity = 8'd80; temperature = 8'd25; data_valid = 1'b1; end
            if (i == 3) begin humidity = 8'd40; temperature = 8'd18; data_valid = 1'b1; end
            if (i == 5) begin humidity = 8'd41; temperature = 8'd19; data_valid = 1'b1; end
            if (i >= 1 && busy) bcnt++;
            if (i >= 11 && i <= 19)
                for (int d = 0; d < 4; d++)
                    if (com == ~(4'b0001 << d) && seg_7 == first_code[d]) saw_first = 1'b1;
            @(negedge clk);
        end
        data_valid = 1'b0;
        chk("busy_len_pending", 32'(bcnt), 32'd18);
        chk("first_shown", 32'(saw_first), 32'd1);
        expect_digits("d41_19", 8'h99, 8'hF9, 8'hF9, 8'h90);

        // Reset in the middle of a conversion.
        pulse(8'd80, 8'd25);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst.seg_7", 32'(seg_7), 32'hFF);
        chk("midrst.com", 32'(com), 32'hF);
        chk("midrst.busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("postrst.busy", 32'(busy), 32'h0);
        expect_digits("postrst", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

        // Random traffic checked by the monitor against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            data_valid = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) < 7) begin
                humidity    = 8'($urandom_range(0, 99));
                temperature = 8'($urandom_range(0, 99));
            end else begin
                humidity    = 8'($urandom_range(0, 255));
                temperature = 8'($urandom_range(0, 255));
            end
        end
        @(negedge clk);
        data_valid = 1'b0;
        repeat (40) @(negedge clk);

        mon_en = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
